// File: rtl/sccb_config_sequencer.sv
// sccb_config_sequencer: walks an external register ROM and writes each entry as a 3-phase SCCB write.
// Define SCCB_HW_RESET_EN to pulse cam_reset for RESET_CYCLES after reset before the power-up wait.
module sccb_config_sequencer #(
  parameter int CLK_DIV = 4,
  parameter int N_REGS = 128,
  parameter logic [7:0] DEV_ADDR = 8'h42,
  parameter int PWRUP_DELAY = 1000,
  parameter int RESET_CYCLES = 100,
  parameter int DELAY_UNIT = 1000,
  localparam int AW = $clog2(N_REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] rom_addr,
  input  logic [15:0]   rom_data,
  output logic          busy,
  output logic          done,
  output logic          cam_reset,
  output logic          cam_pwdn,
  output logic          sioc,
  output logic          siod,
  output logic          siod_oe
);
  localparam int M1 = RESET_CYCLES > PWRUP_DELAY ? RESET_CYCLES : PWRUP_DELAY;
  localparam int M2 = 255 * DELAY_UNIT > CLK_DIV ? 255 * DELAY_UNIT : CLK_DIV;
  localparam int CW = $clog2((M1 > M2 ? M1 : M2) + 1);
  typedef enum logic [2:0] {
    S_HW_RESET, S_PWRUP, S_FETCH, S_DECODE, S_WRITE, S_DELAY, S_DONE
  } state_t;
`ifdef SCCB_HW_RESET_EN
  localparam state_t RST_STATE = S_HW_RESET;
`else
  localparam state_t RST_STATE = S_PWRUP;
`endif
  state_t          r_state, w_state;
  logic [CW-1:0]   r_cnt, w_cnt, w_cnt_inc, w_dly;
  logic [6:0]      r_q, w_q, w_rel;
  logic [AW-1:0]   r_addr, w_addr;
  logic [15:0]     r_data, w_data;
  logic            w_adv, w_wr, w_in_bits;
  logic [4:0]      w_bit;
  logic [31:0]     w_frame;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_dly = CW'(r_data[7:0]) * CW'(DELAY_UNIT);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= RST_STATE;
      r_cnt <= '0;
      r_q <= '0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_q <= w_q;
      r_addr <= w_addr;
      r_data <= w_data;
    end
  always_comb begin
    w_state = r_state;
    w_cnt = w_cnt_inc;
    w_q = r_q;
    w_addr = r_addr;
    w_data = r_data;
    w_adv = 1'b0;
    case (r_state)
      S_HW_RESET: if (r_cnt == CW'(RESET_CYCLES - 1)) begin
        w_state = S_PWRUP;
        w_cnt = '0;
      end
      S_PWRUP: if (r_cnt == CW'(PWRUP_DELAY - 1)) begin
        w_state = S_FETCH;
        w_cnt = '0;
      end
      S_FETCH: begin
        w_state = S_DECODE;
        w_cnt = '0;
      end
      S_DECODE: begin
        w_data = rom_data;
        w_cnt = '0;
        w_q = '0;
        if (rom_data == 16'hFFFF) w_state = S_DONE;
        else if (rom_data[15:8] == 8'hFF) begin
          if (rom_data[7:0] == 8'h00) w_adv = 1'b1;
          else w_state = S_DELAY;
        end else w_state = S_WRITE;
      end
      S_WRITE: if (r_cnt == CW'(CLK_DIV - 1)) begin
        w_cnt = '0;
        if (r_q == 7'd112) w_adv = 1'b1;
        else w_q = r_q + 1'b1;
      end
      S_DELAY: w_adv = w_cnt_inc == w_dly;
      S_DONE: begin
        w_cnt = '0;
        if (start) begin
          w_addr = '0;
          w_state = S_FETCH;
        end
      end
      default: w_state = RST_STATE;
    endcase
    if (w_adv) begin
      w_cnt = '0;
      if (r_addr == AW'(N_REGS - 1)) w_state = S_DONE;
      else begin
        w_addr = r_addr + 1'b1;
        w_state = S_FETCH;
      end
    end
  end
  // Quarters 2..109 carry 27 bits (3 bytes + don't-care bit each), 4 quarters per bit.
  assign w_wr = r_state == S_WRITE;
  assign w_rel = r_q - 7'd2;
  assign w_bit = w_rel[6:2];
  assign w_in_bits = r_q >= 7'd2 && r_q <= 7'd109;
  assign w_frame = {DEV_ADDR, 1'b1, r_data[15:8], 1'b1, r_data[7:0], 1'b1, 5'b0};
  assign sioc = !w_wr || (w_in_bits ? w_rel[1] : (r_q == 7'd0 || r_q >= 7'd111));
  assign siod = !w_wr || (w_in_bits ? w_frame[5'd31 - w_bit] : r_q == 7'd112);
  assign siod_oe = !(w_wr && w_in_bits && (w_bit == 5'd8 || w_bit == 5'd17 || w_bit == 5'd26));
  assign rom_addr = r_addr;
  assign busy = r_state != S_DONE;
  assign done = r_state == S_DONE;
  assign cam_pwdn = 1'b0;
`ifdef SCCB_HW_RESET_EN
  assign cam_reset = r_state == S_HW_RESET;
`else
  assign cam_reset = 1'b0;
`endif
endmodule

// File: tb/tb_sccb_config_sequencer.sv
// tb_sccb_config_sequencer: SCCB bus decoder + scoreboard of expected {id,reg,value} writes per table run.
module tb_sccb_config_sequencer;
  localparam int RC = 10;
  localparam int PD = 20;
  localparam int WR_CYC = 2 + 113 * 4;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [1:0] rom_addr;
  logic [15:0] rom_data = '0;
  logic busy, done, cam_reset, cam_pwdn, sioc, siod, siod_oe;
  logic [15:0] tbl [4];
  logic [23:0] exp_q [$];
  int checks = 0, fails = 0, cyc = 0;
  int n_wr = 0, n_start = 0, first_start = -1, last_start = -1;
  sccb_config_sequencer #(.CLK_DIV(4), .N_REGS(4), .DEV_ADDR(8'h42), .PWRUP_DELAY(PD),
    .RESET_CYCLES(RC), .DELAY_UNIT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .busy(busy), .done(done), .cam_reset(cam_reset), .cam_pwdn(cam_pwdn),
    .sioc(sioc), .siod(siod), .siod_oe(siod_oe));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= tbl[rom_addr];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic load(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    tbl[0] = a; tbl[1] = b; tbl[2] = c; tbl[3] = d;
    for (int i = 0; i < 4; i++) begin
      if (tbl[i] == 16'hFFFF) break;
      if (tbl[i][15:8] != 8'hFF) exp_q.push_back({8'h42, tbl[i]});
    end
  endtask
  task automatic pulse_start(output int e);
    @(negedge clk);
    #1 start = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input int budget, output int t);
    int i = 0;
    while (!done && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("done_timeout", done, 1);
    t = cyc;
  endtask
  logic p_sioc = 1'b1, p_siod = 1'b1, in_frame = 1'b0, saw_cr = 1'b0;
  logic [26:0] sh;
  int nbits = 0;
  always @(negedge clk) begin
    if (cam_reset) saw_cr = 1'b1;
    if (reset) in_frame = 1'b0;
    else if (p_sioc && sioc && p_siod && !siod) begin
      chk("start_in_frame", in_frame, 0);
      in_frame = 1'b1;
      nbits = 0;
      n_start++;
      if (first_start < 0) first_start = cyc;
      last_start = cyc;
    end else if (p_sioc && sioc && !p_siod && siod && in_frame) begin
      chk("bitcnt", nbits, 27);
      chk("wr_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("wr_bytes", {sh[26:19], sh[17:10], sh[8:1]}, exp_q.pop_front());
      n_wr++;
      in_frame = 1'b0;
    end else if (!p_sioc && sioc && in_frame && nbits < 27) begin
      chk("siod_oe", siod_oe, nbits % 9 != 8);
      sh = {sh[25:0], siod};
      nbits++;
    end
    p_sioc = sioc;
    p_siod = siod;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int rel, e, t, addr1, viol;
    load(16'h1280, 16'h1204, 16'h1111, 16'h3A04);
    repeat (3) @(negedge clk);
    chk("rst_addr", rom_addr, 0);
    chk("rst_sioc", sioc, 1);
    chk("rst_siod", siod, 1);
    chk("rst_oe", siod_oe, 1);
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_pwdn", cam_pwdn, 0);
`ifdef SCCB_HW_RESET_EN
    chk("rst_cam_reset", cam_reset, 1);
`else
    chk("rst_cam_reset", cam_reset, 0);
`endif
    #1 reset = 1'b0;
    rel = cyc;
`ifdef SCCB_HW_RESET_EN
    t = -1;
    for (int i = 0; i < 3 * RC && t < 0; i++) begin
      @(negedge clk);
      if (!cam_reset) t = cyc;
    end
    chk("cam_reset_len", t - rel, RC);
`endif
    wait_done(4 * WR_CYC + RC + PD + 50, t);
`ifdef SCCB_HW_RESET_EN
    chk("first_fetch", first_start - rel, RC + PD + 2);
`else
    chk("first_fetch", first_start - rel, PD + 2);
`endif
    chk("nom_nwr", n_wr, 4);
    chk("nom_q", exp_q.size(), 0);
    chk("nom_addr", rom_addr, 3);
    chk("nom_busy", busy, 0);
    chk("cam_reset_off", cam_reset, 0);
    n_wr = 0;
    saw_cr = 1'b0;
    load(16'h1280, 16'h1204, 16'h1111, 16'h3A04);
    pulse_start(e);
    chk("done_fall", done, 0);
    repeat (100) @(negedge clk);
    chk("busy_in_write", busy, 1);
    pulse_start(t);
    wait_done(4 * WR_CYC + 50, t);
    chk("done_latency", t - e, 4 * WR_CYC);
    chk("rs_nwr", n_wr, 4);
    chk("rs_q", exp_q.size(), 0);
    chk("rs_no_cam_reset", saw_cr, 0);
    n_wr = 0;
    load(16'h1280, 16'hFFFF, 16'h1111, 16'h2222);
    pulse_start(e);
    wait_done(2 * WR_CYC, t);
    chk("end_nwr", n_wr, 1);
    chk("end_addr", rom_addr, 1);
    chk("end_q", exp_q.size(), 0);
    n_wr = 0;
    load(16'hFF05, 16'h1111, 16'hFFFF, 16'h0000);
    pulse_start(e);
    addr1 = -1;
    viol = 0;
    for (int i = 0; i < 54; i++) begin
      if (rom_addr == 2'd1 && addr1 < 0) addr1 = cyc;
      if (!sioc || !siod) viol++;
      @(negedge clk);
    end
    wait_done(2 * WR_CYC, t);
    chk("dly_fetch", addr1 - e, 52);
    chk("dly_idle", viol, 0);
    chk("dly_wr_start", last_start - e, 54);
    chk("dly_nwr", n_wr, 1);
    chk("dly_q", exp_q.size(), 0);
    n_wr = 0;
    n_start = 0;
    load(16'h1280, 16'h1204, 16'h1111, 16'h3A04);
    pulse_start(e);
    repeat (202) @(negedge clk);
    chk("mid_started", n_start, 1);
    chk("mid_q50_sioc", sioc, 0);
    #1 reset = 1'b1;
    #1;
    chk("mid_sioc", sioc, 1);
    chk("mid_siod", siod, 1);
    chk("mid_addr", rom_addr, 0);
`ifdef SCCB_HW_RESET_EN
    chk("mid_cam_reset", cam_reset, 1);
`else
    chk("mid_cam_reset", cam_reset, 0);
`endif
    @(negedge clk);
    #1 reset = 1'b0;
    wait_done(4 * WR_CYC + RC + PD + 50, t);
    chk("mid_nwr", n_wr, 4);
    chk("mid_q", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
